// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (idle / burst in progress)
//   STAT_W      : width of each per-requester beat counter (optional stats)
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping modulo NREQ.
// Ports:
//   req [NREQ]  request vector
//   ptr [IW]    search start position (must be < NREQ)
//   any         1 when at least one request is set
//   idx [IW]    index of the chosen request (0 when none)
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    any = 1'b0;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr+k cannot overflow before the modulo fold.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      pos = sum[IW-1:0];
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ requesters. Round-robin packet
// arbitration: a grant is held until a beat carrying last is written or
// MAX_BURST beats have been written, then one idle bubble cycle follows.
// Optional feature macro: FIFO_ARB_STATS_EN (per-requester beat counters).
// Ports:
//   clk, rst          write-domain clock, asynchronous active-high reset
//   s_valid/s_last    per-requester beat valid / end-of-packet
//   s_data            requester i data at [i*DWIDTH +: DWIDTH]
//   s_ready           beat accepted when s_valid[i] & s_ready[i]
//   fifo_full         FIFO full flag
//   fifo_wren/din     FIFO write enable / data
//   busy              1 while a grant is active
//   gnt_idx           current or last granted requester
//   stat_clr/stat_cnt (FIFO_ARB_STATS_EN only) clear / 16-bit saturating
//                     accepted-beat counters, requester i at [i*16 +: 16]
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          s_valid,
  input  logic [NREQ*DWIDTH-1:0]   s_data,
  input  logic [NREQ-1:0]          s_last,
  output logic [NREQ-1:0]          s_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wren,
  output logic [DWIDTH-1:0]        fifo_din,
`ifdef FIFO_ARB_STATS_EN
  input  logic                     stat_clr,
  output logic [NREQ*STAT_W-1:0]   stat_cnt,
`endif
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_idx
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          beat;
  logic          grant_end;

  fifo_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (s_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy      = (state == ARB_BURST);
  // Data follows the grant index even when idle so the FIFO sees stable data.
  assign fifo_din  = s_data[gnt_idx*DWIDTH +: DWIDTH];
  // Write is gated by the current full flag, so the FIFO can never overflow.
  assign beat      = busy & s_valid[gnt_idx] & ~fifo_full;
  assign fifo_wren = beat;
  // last and the burst limit on the same beat give a single release.
  assign grant_end = beat & (s_last[gnt_idx] | (beat_cnt == BW'(MAX_BURST-1)));

  always_comb begin
    s_ready = '0;
    if (busy) s_ready[gnt_idx] = ~fifo_full;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_idx  <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // A granted requester that drops valid keeps the grant; no timeout.
          if (grant_end) begin
            rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            state  <= ARB_IDLE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    // NOTE: the counters are a handful of flops, not a RAM, so they take the
    // reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (beat && gnt_idx == IW'(i) && cnt != {STAT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, compared each cycle against a transaction-level grant model.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DWIDTH    = 8;
  localparam int MAX_BURST = 8;
  localparam int IW        = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        s_valid;
  logic [NREQ*DWIDTH-1:0] s_data;
  logic [NREQ-1:0]        s_last;
  logic [NREQ-1:0]        s_ready;
  logic                   fifo_full;
  logic                   fifo_wren;
  logic [DWIDTH-1:0]      fifo_din;
  logic                   busy;
  logic [IW-1:0]          gnt_idx;
`ifdef FIFO_ARB_STATS_EN
  logic                   stat_clr;
  logic [NREQ*16-1:0]     stat_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fifo_full (fifo_full),
    .fifo_wren (fifo_wren),
    .fifo_din  (fifo_din),
`ifdef FIFO_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .busy      (busy),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester sources: each holds its beat (data stable) until accepted.
  int         rem[NREQ];
  int         pkt_len[NREQ];  // 0 = never assert last
  int         pcnt[NREQ];
  int         seq[NREQ];
  int         step[NREQ];
  bit         pause[NREQ];
  logic [7:0] base[NREQ];

  function automatic bit src_valid(int i);
    return rem[i] > 0 && !pause[i];
  endfunction

  function automatic bit src_last(int i);
    return pkt_len[i] != 0 && pcnt[i] == pkt_len[i] - 1;
  endfunction

  function automatic logic [7:0] src_data(int i);
    return base[i] + 8'(seq[i] * step[i]);
  endfunction

  task automatic src_clear();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; pkt_len[i] = 0; pcnt[i] = 0; seq[i] = 0;
      step[i] = 0; pause[i] = 0; base[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      s_valid[i] = src_valid(i);
      s_last[i]  = src_last(i);
      s_data[i*DWIDTH +: DWIDTH] = src_data(i);
    end
  endtask

  // Grant model: owner = requester holding the grant, -1 when none.
  int m_owner, m_start, m_nb, m_gnt;
  int m_stat[NREQ];

  task automatic model_reset();
    m_owner = -1; m_start = 0; m_nb = 0; m_gnt = 0;
    for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
  endtask

  // Observation of DUT writes.
  int   cyc = 0;
  int   wr_total = 0;
  int   cur_len = 0, cur_req = 0;
  int   b_req[$], b_len[$];
  logic [7:0] w_din[$];
  int   w_cyc[$];
  bit   last_ew;

  task automatic flush();
    if (cur_len > 0) begin
      b_req.push_back(cur_req);
      b_len.push_back(cur_len);
    end
    cur_len = 0;
  endtask

  task automatic tick();
    logic [NREQ-1:0] er;
    bit ew;
    int o;
    bit found;
    drive();
    @(negedge clk);
    if (rst) model_reset();
    er = '0;
    ew = 1'b0;
    o  = m_owner;
    if (o >= 0 && !fifo_full) begin
      er[o] = 1'b1;
      ew = src_valid(o);
    end
    check("s_ready", s_ready, er);
    check("fifo_wren", fifo_wren, ew);
    check("busy", busy, o >= 0);
    check("gnt_idx", gnt_idx, m_gnt);
    check("fifo_din", fifo_din, src_data(m_gnt));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) check("stat_cnt", stat_cnt[i*16 +: 16], m_stat[i]);
`endif
    if (!busy) flush();
    if (fifo_wren) begin
      cur_len++;
      cur_req = gnt_idx;
      wr_total++;
      w_din.push_back(fifo_din);
      w_cyc.push_back(cyc);
    end
    last_ew = ew;
    if (!rst) begin
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) if (stat_clr) m_stat[i] = 0;
      if (!stat_clr && ew && m_stat[o] < 65535) m_stat[o]++;
`endif
      if (o < 0) begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && src_valid((m_start + k) % NREQ)) begin
            found = 1;
            m_owner = (m_start + k) % NREQ;
            m_gnt = m_owner;
            m_nb = 0;
          end
        end
      end else if (ew) begin
        m_nb++;
        if (src_last(o) || m_nb == MAX_BURST) begin
          m_start = (o + 1) % NREQ;
          m_owner = -1;
        end
        pcnt[o] = src_last(o) ? 0 : pcnt[o] + 1;
        rem[o]--;
        seq[o]++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush();
    b_req.delete(); b_len.delete(); w_din.delete(); w_cyc.delete();
  endtask

  int w0;
  bit done;

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    src_clear();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: reset asserted mid-burst with all requesters valid.
    for (int i = 0; i < NREQ; i++) begin rem[i] = 100; base[i] = 8'hA0 + 8'(i); end
    repeat (3) tick();
    check("t1_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t1_ready_async", s_ready, 4'h0);
    check("t1_wren_async", fifo_wren, 1'b0);
    check("t1_busy_async", busy, 1'b0);
    check("t1_gnt_async", gnt_idx, 2'd0);
    tick();
    rst = 1'b0;

    // 2: all valid, single-beat packets -> strict rotation, 2 cycles apart.
    src_clear();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 5; pkt_len[i] = 1; base[i] = 8'hA0 + 8'(i); end
    do_reset();
    repeat (10) tick();
    check("t2_nwrites", w_din.size(), 5);
    for (int k = 0; k < 5 && k < w_din.size(); k++) begin
      check("t2_din", w_din[k], 8'hA0 + 8'(k % 4));
      if (k > 0) check("t2_spacing", w_cyc[k] - w_cyc[k-1], 2);
    end

    // 3: long packet split at MAX_BURST, req2 served between chunks.
    src_clear();
    rem[1] = 20; base[1] = 8'h40; step[1] = 1;
    rem[2] = 1;  pkt_len[2] = 1; base[2] = 8'h77;
    do_reset();
    repeat (30) tick();
    flush();
    check("t3_nbursts", b_req.size(), 4);
    if (b_req.size() == 4) begin
      check("t3_b0_req", b_req[0], 1); check("t3_b0_len", b_len[0], 8);
      check("t3_b1_req", b_req[1], 2); check("t3_b1_len", b_len[1], 1);
      check("t3_b2_req", b_req[2], 1); check("t3_b2_len", b_len[2], 8);
      check("t3_b3_req", b_req[3], 1); check("t3_b3_len", b_len[3], 4);
    end

    // 4: FIFO full for 3 cycles mid-burst: no writes, burst count unchanged.
    src_clear();
    rem[0] = 10; base[0] = 8'h10; step[0] = 1;
    do_reset();
    repeat (3) tick();
    fifo_full = 1'b1;
    w0 = wr_total;
    repeat (3) tick();
    check("t4_writes_full", wr_total - w0, 0);
    check("t4_busy_full", busy, 1'b1);
    fifo_full = 1'b0;
    repeat (15) tick();
    flush();
    check("t4_nbursts", b_req.size(), 2);
    if (b_req.size() == 2) begin
      check("t4_b0_len", b_len[0], 8);
      check("t4_b1_len", b_len[1], 2);
    end

    // 5: granted requester pauses mid-packet; others must wait.
    src_clear();
    rem[0] = 10; pkt_len[0] = 4; base[0] = 8'h10; step[0] = 1;
    rem[3] = 2;  pkt_len[3] = 1; base[3] = 8'h30; step[3] = 1;
    do_reset();
    repeat (3) tick();
    pause[0] = 1'b1;
    w0 = wr_total;
    repeat (5) tick();
    check("t5_writes_pause", wr_total - w0, 0);
    check("t5_gnt_pause", gnt_idx, 2'd0);
    check("t5_busy_pause", busy, 1'b1);
    pause[0] = 1'b0;
    repeat (20) tick();
    flush();
    check("t5_nbursts", b_req.size(), 5);
    if (b_req.size() >= 2) begin
      check("t5_b0_req", b_req[0], 0); check("t5_b0_len", b_len[0], 4);
      check("t5_b1_req", b_req[1], 3); check("t5_b1_len", b_len[1], 1);
    end

    // Random traffic with backpressure, pauses and occasional reset.
    src_clear();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(3) == 0) begin
          rem[i] = $urandom_range(12, 1);
          pkt_len[i] = $urandom_range(5);
          pcnt[i] = 0;
          base[i] = 8'($urandom);
          step[i] = 1;
        end
        pause[i] = ($urandom_range(9) == 0);
      end
      fifo_full = ($urandom_range(4) == 0);
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    fifo_full = 1'b0;

`ifdef FIFO_ARB_STATS_EN
    // 6: counter saturation, then clear colliding with an accepted beat.
    src_clear();
    rem[2] = 70000; base[2] = 8'h22; step[2] = 1;
    do_reset();
    done = 0;
    for (int n = 0; n < 90000 && !done; n++) begin
      tick();
      done = (rem[2] == 0);
    end
    check("t6_sat_done", done, 1'b1);
    check("t6_sat", stat_cnt[2*16 +: 16], 16'hFFFF);
    rem[2] = 20;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (m_owner == 2 && src_valid(2)) done = 1;
      else tick();
    end
    check("t6_clr_ready", done, 1'b1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("t6_clr_beat", last_ew, 1'b1);
    check("t6_clr", stat_cnt[2*16 +: 16], 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
